// File: rtl/seq_mult_int_hs_if.sv
// rtl/seq_mult_int_hs_if.sv - operand/result handshake bundle for the sequential signed multiplier
interface seq_mult_int_hs_if #(
  parameter int BIT_WIDTH = 8,
  parameter int OUT_WIDTH = 2 * BIT_WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [BIT_WIDTH-1:0] inp_a;
  logic [BIT_WIDTH-1:0] inp_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_WIDTH-1:0] out;
  logic                 busy;

  modport master (
    output in_valid, inp_a, inp_b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, inp_a, inp_b, out_ready,
    output in_ready, out_valid, out, busy
  );
endinterface

// File: rtl/seq_mult_int_hs.sv
// rtl/seq_mult_int_hs.sv - radix-2 shift-add signed multiplier with valid/ready handshakes
// Optional truncated-multiplier mode selected by macro MULT_APPROX_TRUNC_EN.
module seq_mult_int_hs #(
  parameter int BIT_WIDTH  = 8,
  parameter int OUT_WIDTH  = 2 * BIT_WIDTH,
  parameter int TRUNC_BITS = 2
) (
  input  logic               clk,
  input  logic               rst,
  seq_mult_int_hs_if.slave   bus
);
  localparam int CNT_W = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
`ifdef MULT_APPROX_TRUNC_EN
  localparam int FIRST = TRUNC_BITS;
`else
  localparam int FIRST = 0;
`endif
  localparam logic [CNT_W-1:0] CNT_FIRST = CNT_W'(FIRST);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BIT_WIDTH - 1);

  if (OUT_WIDTH != 2 * BIT_WIDTH || BIT_WIDTH < 2 ||
      TRUNC_BITS < 0 || TRUNC_BITS >= BIT_WIDTH) begin : g_param_check
    $error("seq_mult_int_hs: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  logic [OUT_WIDTH-1:0] a_q;
  logic [BIT_WIDTH-1:0] b_q;
  logic [OUT_WIDTH-1:0] acc_q;
  logic [OUT_WIDTH-1:0] out_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 in_ready_q;
  logic                 out_valid_q;
  logic                 busy_q;

  logic [OUT_WIDTH-1:0] term_d;
  logic [OUT_WIDTH-1:0] acc_d;
  logic                 last_d;

  // MSB of the multiplier carries negative weight, so its partial product is subtracted.
  always_comb begin
    term_d = '0;
    last_d = (cnt_q == CNT_LAST);
    if (b_q[cnt_q]) begin
      term_d = a_q << cnt_q;
    end
    acc_d = last_d ? (acc_q - term_d) : (acc_q + term_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid && in_ready_q) begin
            a_q        <= {{(OUT_WIDTH-BIT_WIDTH){bus.inp_a[BIT_WIDTH-1]}}, bus.inp_a};
            b_q        <= bus.inp_b;
            acc_q      <= '0;
            cnt_q      <= CNT_FIRST;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= BUSY;
          end
        end
        BUSY: begin
          acc_q <= acc_d;
          if (last_d) begin
            out_q       <= acc_d;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= DONE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.busy      = busy_q;
endmodule
